// File: rtl/beam_wr_ctrl_if.sv
// Sample stream into the beam write controller: valid/last/ready handshake
// with one data word per accepted beat.
interface beam_wr_ctrl_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  i_tvalid;
  logic [DATA_WIDTH-1:0] i_tdata;
  logic                  i_tlast;
  logic                  o_tready;

  modport master (output i_tvalid, output i_tdata, output i_tlast, input o_tready);
  modport slave  (input i_tvalid, input i_tdata, input i_tlast, output o_tready);
endinterface

// File: rtl/beam_wr_ctrl.sv
// Write-side controller for the beam buffer: normalises each input block to
// BLOCK_LEN words (zero-pad or truncate) and tracks the 4-block group index.
module beam_wr_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int BLOCK_LEN  = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  beam_wr_ctrl_if.slave         stream,
  output logic                  o_wr_wen,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_rvalid,
  output logic [1:0]            o_blk_idx,
  output logic                  o_grp_done,
  output logic                  o_err_short,
  output logic                  o_err_long
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] PAD   = 3'd2;
  localparam logic [2:0] DROP  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BLOCK_LEN - 1);
  localparam logic [GAP_W-1:0]      GAP_END   = GAP_W'(GAP_CYCLES - 1);

  logic [2:0]            state, state_d;
  logic [ADDR_WIDTH-1:0] cnt, cnt_d;
  logic [GAP_W-1:0]      gap_cnt, gap_d;
  logic                  ready, ready_d;
  logic                  accept;
  logic                  wen_d, rvalid_d, short_d, long_d, fall;
  logic [DATA_WIDTH-1:0] data_d;
  logic [ADDR_WIDTH-1:0] addr_d;

  assign stream.o_tready = ready;
  assign accept          = stream.i_tvalid & ready;

  // cnt always holds the next write address; it is 0 in IDLE, so IDLE and
  // WRITE share the beat-write path.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    gap_d    = gap_cnt;
    wen_d    = 1'b0;
    data_d   = '0;
    addr_d   = '0;
    short_d  = 1'b0;
    long_d   = 1'b0;

    case (state)
      IDLE, WRITE: begin
        if (accept) begin
          wen_d  = 1'b1;
          data_d = stream.i_tdata;
          addr_d = cnt;
          if (cnt == LAST_ADDR) begin
            cnt_d = '0;
            if (stream.i_tlast) begin
              state_d = GAP;
            end else begin
              long_d  = 1'b1;
              state_d = DROP;
            end
          end else begin
            cnt_d   = cnt + 1'b1;
            state_d = stream.i_tlast ? PAD : WRITE;
          end
        end
      end
      PAD: begin
        wen_d  = 1'b1;
        addr_d = cnt;
        if (cnt == LAST_ADDR) begin
          short_d = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DROP: begin
        if (accept && stream.i_tlast) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_END) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        gap_d   = '0;
      end
    endcase
  end

  // The envelope covers every write plus bubbles inside WRITE; DROP and GAP
  // are outside it, so it falls the cycle after the block's final write.
  always_comb begin
    rvalid_d = wen_d | (state_d == WRITE) | (state_d == PAD);
    ready_d  = (state_d == IDLE) | (state_d == WRITE) | (state_d == DROP);
    fall     = o_rvalid & ~rvalid_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      gap_cnt     <= '0;
      ready       <= 1'b0;
      o_wr_wen    <= 1'b0;
      o_wr_data   <= '0;
      o_wr_addr   <= '0;
      o_rvalid    <= 1'b0;
      o_blk_idx   <= 2'd0;
      o_grp_done  <= 1'b0;
      o_err_short <= 1'b0;
      o_err_long  <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      gap_cnt     <= gap_d;
      ready       <= ready_d;
      o_wr_wen    <= wen_d;
      o_wr_data   <= data_d;
      o_wr_addr   <= addr_d;
      o_rvalid    <= rvalid_d;
      o_err_short <= short_d;
      o_err_long  <= long_d;
      o_grp_done  <= fall & (o_blk_idx == 2'd3);
      if (fall) begin
        o_blk_idx <= o_blk_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_beam_wr_ctrl.sv
// Directed self-checking bench for beam_wr_ctrl: normal, group wrap, short,
// long, mid-block reset and bubble traffic with hand-computed expectations.
module tb_beam_wr_ctrl;

  localparam int DW  = 64;
  localparam int AW  = 6;
  localparam int BL  = 64;
  localparam int GAPC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  beam_wr_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  logic          wr_wen;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          rvalid;
  logic [1:0]    blk_idx;
  logic          grp_done;
  logic          err_short;
  logic          err_long;

  beam_wr_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BLOCK_LEN (BL),
    .GAP_CYCLES(GAPC)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .stream     (bus.slave),
    .o_wr_wen   (wr_wen),
    .o_wr_data  (wr_data),
    .o_wr_addr  (wr_addr),
    .o_rvalid   (rvalid),
    .o_blk_idx  (blk_idx),
    .o_grp_done (grp_done),
    .o_err_short(err_short),
    .o_err_long (err_long)
  );

  int checks = 0;
  int errors = 0;

  int          wr_count, addr_err, exp_addr, short_cnt, long_cnt, grp_cnt, grp_at_fall;
  int          cur_hi, cur_lo, first_idx;
  bit          seen_wr, seen_hi;
  logic        prev_rv;
  logic [AW-1:0] short_addr, long_addr;
  logic [DW-1:0] mem [BL];
  int          hi_runs[$];
  int          lo_runs[$];
  logic [1:0]  fall_idx[$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input int tag, input int i);
    return {8'hB0, 8'(tag), 16'h5A00, 32'(i)};
  endfunction

  // Every cycle advance goes through here so outputs are recorded once per cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_wen) begin
      if (!seen_wr) first_idx = int'(blk_idx);
      seen_wr = 1'b1;
      wr_count++;
      if (int'(wr_addr) != exp_addr) addr_err++;
      exp_addr = (int'(wr_addr) + 1) % BL;
      mem[wr_addr] = wr_data;
    end
    if (err_short) begin short_cnt++; short_addr = wr_addr; end
    if (err_long)  begin long_cnt++;  long_addr  = wr_addr; end
    if (grp_done) grp_cnt++;
    if (rvalid) begin
      if (!prev_rv && seen_hi) lo_runs.push_back(cur_lo);
      cur_hi++;
      seen_hi = 1'b1;
      cur_lo = 0;
    end else begin
      if (prev_rv) begin
        hi_runs.push_back(cur_hi);
        fall_idx.push_back(blk_idx);
        if (grp_done) grp_at_fall++;
      end
      cur_hi = 0;
      cur_lo++;
    end
    prev_rv = rvalid;
  endtask

  task automatic clearRec();
    wr_count = 0; addr_err = 0; exp_addr = 0; short_cnt = 0; long_cnt = 0;
    grp_cnt = 0; grp_at_fall = 0; cur_hi = 0; cur_lo = 0; first_idx = -1;
    seen_wr = 1'b0; seen_hi = 1'b0; prev_rv = rvalid;
    short_addr = '0; long_addr = '0;
    hi_runs.delete(); lo_runs.delete(); fall_idx.delete();
    for (int a = 0; a < BL; a++) mem[a] = '1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic l, output int stalls);
    stalls = 0;
    bus.i_tvalid = v;
    bus.i_tdata  = d;
    bus.i_tlast  = l;
    while (v && !bus.o_tready && stalls < 300) begin
      tick();
      stalls++;
    end
    if (stalls >= 300) checkOutput("tready_timeout", 64'(bus.o_tready), 64'd1);
    tick();
  endtask

  task automatic idle(input int n);
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic sendBlock(input int tag, input int n, output int late_stalls);
    int s;
    late_stalls = 0;
    for (int i = 1; i <= n; i++) begin
      applyStimulus(1'b1, beat_data(tag, i), i == n, s);
      if (i > BL) late_stalls += s;
    end
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
  endtask

  function automatic int dataBad(input int tag, input int valid_words);
    int bad = 0;
    for (int a = 0; a < BL; a++) begin
      if (a < valid_words) begin
        if (mem[a] !== beat_data(tag, a + 1)) bad++;
      end else begin
        if (mem[a] !== 64'd0) bad++;
      end
    end
    return bad;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int late, s, ready_hi, bad;
    logic [2:0] gap_ready;

    bus.i_tvalid = 1'b0;
    bus.i_tdata  = '0;
    bus.i_tlast  = 1'b0;
    #3;
    checkOutput("rst_tready", 64'(bus.o_tready), 64'd0);
    checkOutput("rst_outputs", {wr_wen, rvalid, grp_done, err_short, err_long, blk_idx, wr_addr}, 64'd0);
    clearRec();
    tick();
    tick();
    checkOutput("rst_hold_tready", 64'(bus.o_tready), 64'd0);
    checkOutput("rst_hold_wen", 64'(wr_wen), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] group wrap");
    clearRec();
    for (int b = 0; b < 4; b++) sendBlock(b + 1, BL, late);
    idle(6);
    checkOutput("grp_wr_count", 64'(wr_count), 64'd256);
    checkOutput("grp_addr_err", 64'(addr_err), 64'd0);
    checkOutput("grp_fall_count", 64'(fall_idx.size()), 64'd4);
    if (fall_idx.size() == 4)
      checkOutput("grp_idx_seq", 64'({fall_idx[0], fall_idx[1], fall_idx[2], fall_idx[3]}), 64'b01_10_11_00);
    checkOutput("grp_done_cnt", 64'(grp_cnt), 64'd1);
    checkOutput("grp_done_at_fall", 64'(grp_at_fall), 64'd1);
    checkOutput("grp_gap_runs", 64'(lo_runs.size()), 64'd3);
    bad = 0;
    foreach (lo_runs[k]) if (lo_runs[k] != GAPC) bad++;
    checkOutput("grp_gap_len", 64'(bad), 64'd0);
    checkOutput("grp_data_last", 64'(dataBad(4, BL)), 64'd0);

    $display("[TB] normal block");
    clearRec();
    sendBlock(5, BL, late);
    idle(6);
    checkOutput("norm_wr_count", 64'(wr_count), 64'd64);
    checkOutput("norm_addr_err", 64'(addr_err), 64'd0);
    checkOutput("norm_data", 64'(dataBad(5, BL)), 64'd0);
    checkOutput("norm_rv_run", 64'((hi_runs.size() == 1) ? hi_runs[0] : -1), 64'd64);
    checkOutput("norm_first_idx", 64'(first_idx), 64'd0);
    checkOutput("norm_blk_idx", 64'(blk_idx), 64'd1);
    checkOutput("norm_errs", 64'(short_cnt + long_cnt), 64'd0);

    $display("[TB] short block");
    clearRec();
    sendBlock(6, 10, late);
    ready_hi = 0;
    for (int k = 0; k < BL - 10; k++) begin
      if (bus.o_tready) ready_hi++;
      tick();
    end
    idle(6);
    checkOutput("short_wr_count", 64'(wr_count), 64'd64);
    checkOutput("short_addr_err", 64'(addr_err), 64'd0);
    checkOutput("short_data_pad", 64'(dataBad(6, 10)), 64'd0);
    checkOutput("short_ready_pad", 64'(ready_hi), 64'd0);
    checkOutput("short_err_cnt", 64'(short_cnt), 64'd1);
    checkOutput("short_err_addr", 64'(short_addr), 64'd63);
    checkOutput("short_no_long", 64'(long_cnt), 64'd0);
    checkOutput("short_rv_run", 64'((hi_runs.size() == 1) ? hi_runs[0] : -1), 64'd64);

    $display("[TB] long block");
    clearRec();
    sendBlock(7, 70, late);
    gap_ready[0] = bus.o_tready;
    tick();
    gap_ready[1] = bus.o_tready;
    tick();
    gap_ready[2] = bus.o_tready;
    idle(4);
    checkOutput("long_wr_count", 64'(wr_count), 64'd64);
    checkOutput("long_addr_err", 64'(addr_err), 64'd0);
    checkOutput("long_data", 64'(dataBad(7, BL)), 64'd0);
    checkOutput("long_err_cnt", 64'(long_cnt), 64'd1);
    checkOutput("long_err_addr", 64'(long_addr), 64'd63);
    checkOutput("long_drop_stalls", 64'(late), 64'd0);
    checkOutput("long_gap_ready", 64'(gap_ready), 64'b100);
    checkOutput("long_rv_run", 64'((hi_runs.size() == 1) ? hi_runs[0] : -1), 64'd64);
    checkOutput("long_blk_idx", 64'(blk_idx), 64'd3);

    $display("[TB] reset mid-block");
    clearRec();
    sendBlock(8, 30, late);
    bus.i_tvalid = 1'b1;
    bus.i_tlast  = 1'b0;
    checkOutput("mid_pre_rvalid", 64'(rvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_async_wen", 64'(wr_wen), 64'd0);
    checkOutput("mid_async_rvalid", 64'(rvalid), 64'd0);
    checkOutput("mid_async_tready", 64'(bus.o_tready), 64'd0);
    checkOutput("mid_async_all", {wr_data[31:0], grp_done, err_short, err_long, blk_idx, wr_addr}, 64'd0);
    bus.i_tvalid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clearRec();
    sendBlock(9, BL, late);
    idle(6);
    checkOutput("mid_wr_count", 64'(wr_count), 64'd64);
    checkOutput("mid_addr_err", 64'(addr_err), 64'd0);
    checkOutput("mid_first_idx", 64'(first_idx), 64'd0);
    checkOutput("mid_data", 64'(dataBad(9, BL)), 64'd0);

    $display("[TB] bubbles");
    clearRec();
    for (int i = 1; i <= BL; i++) begin
      applyStimulus(1'b1, beat_data(10, i), i == BL, s);
      if (i < BL) applyStimulus(1'b0, '0, 1'b0, s);
    end
    idle(6);
    checkOutput("bub_rv_run", 64'((hi_runs.size() == 1) ? hi_runs[0] : -1), 64'd127);
    checkOutput("bub_wr_count", 64'(wr_count), 64'd64);
    checkOutput("bub_addr_err", 64'(addr_err), 64'd0);
    checkOutput("bub_data", 64'(dataBad(10, BL)), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
